// File: rtl/score_display_driver_pkg.sv
// Shared constants, state encoding and helpers for the score display path.
// Seven-segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package score_display_driver_pkg;

  localparam int MAX_DISPLAY = 9999;
  localparam int NUM_DIGITS  = 4;
  localparam int BIN_W       = 14;
  localparam int BCD_W       = 16;
  localparam int SR_W        = BCD_W + BIN_W;
  localparam int ITER_LAST   = BIN_W - 1;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } conv_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  function automatic logic [BIN_W-1:0] saturate(input logic [31:0] value);
    if (value > 32'(MAX_DISPLAY)) return BIN_W'(MAX_DISPLAY);
    return value[BIN_W-1:0];
  endfunction

  // One double-dabble step: correct every BCD nibble that would overflow, then shift.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] tmp;
    tmp = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (tmp[BIN_W + 4*i +: 4] >= 4'd5) begin
        tmp[BIN_W + 4*i +: 4] = tmp[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    return {tmp[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/score_display_driver_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: watches the input value, saturates it and
// runs double-dabble, then raises a one-cycle commit strobe with the result.
module bin2bcd_seq
  import score_display_driver_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       val_i,
  output logic [BCD_W-1:0]  bcd_o,
  output logic              commit_o,
  output logic              busy_o
);

  conv_state_e       state_q, state_d;
  logic [31:0]       last_val_q, last_val_d;
  logic [31:0]       cap_q, cap_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [3:0]        iter_q, iter_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      last_val_q <= '0;
      cap_q      <= '0;
      sr_q       <= '0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      cap_q      <= cap_d;
      sr_q       <= sr_d;
      iter_q     <= iter_d;
    end
  end

  // last_val only moves at commit, so a value that changed mid-conversion is
  // picked up by the IDLE compare that follows.
  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    cap_d      = cap_q;
    sr_d       = sr_q;
    iter_d     = iter_q;
    case (state_q)
      ST_IDLE: begin
        if (val_i != last_val_q) begin
          cap_d   = val_i;
          sr_d    = {{BCD_W{1'b0}}, saturate(val_i)};
          iter_d  = '0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        sr_d   = dabble_step(sr_q);
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'(ITER_LAST)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        last_val_d = cap_q;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bcd_o    = sr_q[SR_W-1:BIN_W];
  assign commit_o = (state_q == ST_COMMIT);
  assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: rtl/score_display_driver.sv
// Score display driver: converts the selected value to BCD and scans it onto a
// common-anode 4-digit seven-segment display with leading-zero blanking.
module score_display_driver
  import score_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] val,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [BCD_W-1:0] bcd;
  logic             commit;

  logic [BCD_W-1:0] digits_q, digits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       blank;
  logic [3:0]       cur_digit;

  bin2bcd_seq u_bin2bcd (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .val_i    (val),
    .bcd_o    (bcd),
    .commit_o (commit),
    .busy_o   (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= 4'b1110;
      seg_q    <= SEG_0;
    end else begin
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  // A digit is blank only if it and every more significant digit are zero.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (digits_q[15:12] == 4'd0);
    blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
    blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
  end

  always_comb begin
    digits_d  = commit ? bcd : digits_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    cur_digit = digits_q[{idx_q, 2'b00} +: 4];
    an_d      = ~(4'b0001 << idx_q);
    seg_d     = blank[idx_q] ? SEG_BLANK : seg_encode(cur_digit);
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display_driver.sv
// Self-checking bench for score_display_driver: reset state, table-driven display
// vectors, multi-cycle corner sequences and randomized values against a decimal model.
module tb_score_display_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] val = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        busy;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct {
    logic [31:0] v;
    logic [6:0]  s3, s2, s1, s0;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  score_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .val   (val),
    .seg   (seg),
    .an    (an),
    .dp    (dp),
    .busy  (busy)
  );

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Decimal reference: clamp, take digit at position pos, blank leading zeros.
  function automatic logic [6:0] modelSeg(input logic [31:0] v, input int pos);
    longint s;
    longint p;
    s = (v > 32'd9999) ? 9999 : longint'(v);
    p = 1;
    for (int k = 0; k < pos; k++) p = p * 10;
    if (pos > 0 && s < p) return 7'h7F;
    return segOf(int'((s / p) % 10));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic waitSettled(input string name);
    int idle = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (busy === 1'b0) idle++;
      else idle = 0;
      if (idle >= 3) break;
    end
    check({name, " settle"}, 32'(idle >= 3), 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] v);
    val = v;
    waitSettled("apply");
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] cap[4];
    logic [3:0] seen;
    int bad;
    seen = '0;
    bad = 0;
    for (int k = 0; k < 4; k++) cap[k] = 7'h7E;
    for (int n = 0; n < 5*DIV; n++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin cap[0] = seg; seen[0] = 1'b1; end
        4'b1101: begin cap[1] = seg; seen[1] = 1'b1; end
        4'b1011: begin cap[2] = seg; seen[2] = 1'b1; end
        4'b0111: begin cap[3] = seg; seen[3] = 1'b1; end
        default: bad++;
      endcase
    end
    check({tag, " an valid"}, 32'(bad), 32'd0);
    check({tag, " slots seen"}, 32'(seen), 32'hF);
    check({tag, " digit3"}, 32'(cap[3]), 32'(e3));
    check({tag, " digit2"}, 32'(cap[2]), 32'(e2));
    check({tag, " digit1"}, 32'(cap[1]), 32'(e1));
    check({tag, " digit0"}, 32'(cap[0]), 32'(e0));
  endtask

  initial begin
    int highs;
    int rises;
    int gap;
    int curGap;
    int changes;
    logic prevBusy;
    logic [3:0] anArr[13];
    logic [31:0] rv;

    vecs.push_back('{32'd7,         7'h7F, 7'h7F, 7'h7F, 7'h78});
    vecs.push_back('{32'd1005,      7'h79, 7'h40, 7'h40, 7'h12});
    vecs.push_back('{32'hFFFFFFFF,  7'h10, 7'h10, 7'h10, 7'h10});
    vecs.push_back('{32'd10000,     7'h10, 7'h10, 7'h10, 7'h10});
    vecs.push_back('{32'd0,         7'h7F, 7'h7F, 7'h7F, 7'h40});
    vecs.push_back('{32'd100,       7'h7F, 7'h79, 7'h40, 7'h40});
    vecs.push_back('{32'd9999,      7'h10, 7'h10, 7'h10, 7'h10});
    vecs.push_back('{32'd50,        7'h7F, 7'h7F, 7'h12, 7'h40});

    // Reset state
    repeat (3) @(negedge clk);
    check("reset an", 32'(an), 32'h0000000E);
    check("reset seg", 32'(seg), 32'h00000040);
    check("reset dp", 32'(dp), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    highs = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy) highs++;
    end
    check("idle after reset busy", 32'(highs), 32'd0);
    checkOutput("zero", 7'h7F, 7'h7F, 7'h7F, 7'h40);

    // 1234: busy width and anode scan order
    val = 32'd1234;
    highs = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) highs++;
    end
    check("1234 busy cycles", 32'(highs), 32'd15);
    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      anArr[n] = an;
    end
    changes = 0;
    for (int k = 0; k < 12; k++) if (anArr[k+1] != anArr[k]) changes++;
    check("an change count", 32'(changes), 32'd3);
    for (int k = 0; k < 9; k++) begin
      check("an rotation", 32'(anArr[k+4]), 32'({anArr[k][2:0], anArr[k][3]}));
    end
    checkOutput("1234", 7'h79, 7'h24, 7'h30, 7'h19);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v);
      checkOutput($sformatf("vec%0d", i), vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0);
    end

    // Value changes mid-conversion: two back-to-back conversions, final 56
    val = 32'd12;
    highs = 0; rises = 0; gap = 0; curGap = 0; prevBusy = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (n == 5) val = 32'd56;
      @(negedge clk);
      if (busy) begin
        highs++;
        if (!prevBusy) begin
          rises++;
          if (rises == 2) gap = curGap;
        end
        curGap = 0;
      end else begin
        curGap++;
      end
      prevBusy = busy;
    end
    check("retrigger conversions", 32'(rises), 32'd2);
    check("retrigger idle gap", 32'(gap), 32'd1);
    check("retrigger busy total", 32'(highs), 32'd30);
    waitSettled("56");
    checkOutput("56", 7'h7F, 7'h7F, 7'h12, 7'h02);

    // Reset in the middle of converting 4321
    val = 32'd4321;
    repeat (7) @(negedge clk);
    check("pre-abort busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort seg", 32'(seg), 32'h00000040);
    check("abort an", 32'(an), 32'h0000000E);
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) highs++;
    end
    check("4321 busy cycles", 32'(highs), 32'd15);
    waitSettled("4321");
    checkOutput("4321", 7'h19, 7'h30, 7'h24, 7'h79);

    // Randomized values against the decimal model
    for (int i = 0; i < 24; i++) begin
      rv = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 11000));
      applyStimulus(rv);
      checkOutput($sformatf("rand %0d", rv), modelSeg(rv, 3), modelSeg(rv, 2),
                  modelSeg(rv, 1), modelSeg(rv, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
